seq_mult_32: RTL and testbench

SEQ_MULT_32 -- requirements
Module: seq_mult_32

---
 rtl/seq_mult_32_pkg.sv | 23 ++
 rtl/seq_mult_32_addsub.sv | 27 ++
 rtl/seq_mult_32.sv | 122 ++++++++++++
 tb/tb_seq_mult_32.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seq_mult_32_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: widths,
// counter limit and FSM state encodings.
package seq_mult_32_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(DATA_W);

  // Counter value of the final shift-add step
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // FSM encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_COMPUTE = ST_COMPUTE,
    S_DONE    = ST_DONE
  } state_t;

endpackage

// File: rtl/seq_mult_32_addsub.sv
// 32-bit ripple-carry add/subtract: sum = x + (sna ? ~y + 1 : y).
// cout is the raw carry out of the top bit.
module seq_mult_32_addsub
  import seq_mult_32_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              sna,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W:0]   c;
  logic [DATA_W-1:0] yi;

  // Subtract is add of the inverted operand with carry-in 1
  assign yi   = y ^ {DATA_W{sna}};
  assign c[0] = sna;

  for (genvar i = 0; i < DATA_W; i++) begin : g_fa
    assign sum[i]   = x[i] ^ yi[i] ^ c[i];
    assign c[i+1]   = (x[i] & yi[i]) | (c[i] & (x[i] ^ yi[i]));
  end

  assign cout = c[DATA_W];

endmodule

// File: rtl/seq_mult_32.sv
// Sequential shift-add 32x32 -> 64 multiplier, one step per cycle.
// Optional signed operands with macro SEQ_MULT_SIGNED_EN (adds SIGNED port).
// Timing: START accepted on edge E -> 32 COMPUTE cycles -> DONE state ->
// DONE/HI/LO registered on edge E+33.
module seq_mult_32
  import seq_mult_32_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic              SIGNED,
`endif
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  state_t              state, state_nxt;
  logic [PROD_W-1:0]   acc;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [CNT_W-1:0]    cnt;
  logic                sgn_q;

  logic                accept, last, add_en, sna, top;
  logic [DATA_W-1:0]   sum, hi_nxt;
  logic                cout;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and step control
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (cnt == CNT_LAST);
    case (state)
      S_IDLE: begin
        accept = START;
        if (START) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        accept    = START;
        state_nxt = START ? S_COMPUTE : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign BUSY = (state == S_COMPUTE);

  // Shift-add datapath: top step of a signed multiply subtracts
  assign add_en = b_q[cnt];
  assign sna    = sgn_q & last;

  seq_mult_32_addsub u_addsub (
    .x    (acc[PROD_W-1:DATA_W]),
    .y    (a_q),
    .sna  (sna),
    .sum  (sum),
    .cout (cout)
  );

  // Bit shifted into acc[63]: carry (unsigned), 33-bit sign (signed add),
  // or plain zero/sign extension when no add occurs
  always_comb begin
    hi_nxt = acc[PROD_W-1:DATA_W];
    top    = sgn_q & acc[PROD_W-1];
    if (add_en) begin
      hi_nxt = sum;
      top    = sgn_q ? (acc[PROD_W-1] ^ a_q[DATA_W-1] ^ sna ^ cout) : cout;
    end
  end

`ifdef SEQ_MULT_SIGNED_EN
  logic sgn_in;
  assign sgn_in = SIGNED;
`else
  logic sgn_in;
  assign sgn_in = 1'b0;
`endif

  // Operand capture, accumulator/counter stepping, output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      sgn_q <= 1'b0;
      DONE  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        sgn_q <= sgn_in;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == S_COMPUTE) begin
        acc <= {top, hi_nxt, acc[DATA_W-1:1]};
        if (!last) cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      DONE <= (state == S_DONE);
      if (state == S_DONE) begin
        HI <= acc[PROD_W-1:DATA_W];
        LO <= acc[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_32.sv
// Directed self-checking bench for seq_mult_32 (signed vectors when
// SEQ_MULT_SIGNED_EN is defined).
module tb_seq_mult_32;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [31:0] A = '0, B = '0;
`ifdef SEQ_MULT_SIGNED_EN
  logic        SIGNED = 1'b0;
`endif
  logic        BUSY, DONE;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  int lat, bcnt, ndone;

  seq_mult_32 dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
`ifdef SEQ_MULT_SIGNED_EN
    .SIGNED(SIGNED),
`endif
    .BUSY  (BUSY),
    .DONE  (DONE),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive a request for one accepting edge; returns #1 after that edge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    A = a;
    B = b;
`ifdef SEQ_MULT_SIGNED_EN
    SIGNED = s;
`else
    if (s) $display("note: signed vector skipped in unsigned build");
`endif
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // Count edges until DONE (bounded) and cycles with BUSY high
  task automatic wait_done(output int n, output int b);
    n = 0;
    b = BUSY ? 1 : 0;
    while (!DONE && n < 40) begin
      @(posedge CLK); #1;
      n++;
      if (BUSY) b++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic [31:0] ehi, input logic [31:0] elo);
    start_op(a, b, s);
    wait_done(lat, bcnt);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_hi"},  64'(HI), 64'(ehi));
    chk({tag, "_lo"},  64'(LO), 64'(elo));
    @(posedge CLK); #1;
    chk({tag, "_pulse"}, 64'(DONE), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_hi",   64'(HI),   64'd0);
    chk("rst_lo",   64'(LO),   64'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Basic multiply, with BUSY duration
    start_op(32'd3, 32'd5, 1'b0);
    wait_done(lat, bcnt);
    chk("basic_lat",  64'(lat),  64'd33);
    chk("basic_busy", 64'(bcnt), 64'd32);
    chk("basic_hi",   64'(HI),   64'h0);
    chk("basic_lo",   64'(LO),   64'hF);
    @(posedge CLK); #1;
    chk("basic_pulse", 64'(DONE), 64'd0);
    chk("basic_hold",  64'(LO),   64'hF);

    // Maximum unsigned operands
    run("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run("mix", 32'h1234_5678, 32'h0000_0010, 1'b0, 32'h0000_0001, 32'h2345_6780);

`ifdef SEQ_MULT_SIGNED_EN
    run("sgn_neg", 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("sgn_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
    run("sgn_off", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000);
`endif

    // START while busy is ignored
    start_op(32'h0000_FFFF, 32'h0001_0001, 1'b0);
    repeat (9) @(posedge CLK);
    #1;
    A = 32'd7; B = 32'd7; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(lat, bcnt);
    chk("ign_lat", 64'(lat + 10), 64'd33);
    chk("ign_hi",  64'(HI), 64'h0);
    chk("ign_lo",  64'(LO), 64'hFFFF_FFFF);
    ndone = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE) ndone++;
    end
    chk("ign_single", 64'(ndone), 64'd0);

    // Reset mid-operation aborts with no DONE
    start_op(32'd11, 32'd13, 1'b0);
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_busy", 64'(BUSY), 64'd0);
    chk("abort_done", 64'(DONE), 64'd0);
    chk("abort_hi",   64'(HI),   64'd0);
    chk("abort_lo",   64'(LO),   64'd0);
    ndone = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE) ndone++;
    end
    chk("abort_nodone", 64'(ndone), 64'd0);

    // Back-to-back: new START raised in the DONE cycle
    start_op(32'd6, 32'd7, 1'b0);
    wait_done(lat, bcnt);
    chk("b2b1_lo", 64'(LO), 64'd42);
    start_op(32'd2, 32'd9, 1'b0);
    chk("b2b_busy", 64'(BUSY), 64'd1);
    wait_done(lat, bcnt);
    chk("b2b_lat", 64'(lat), 64'd33);
    chk("b2b_hi",  64'(HI),  64'h0);
    chk("b2b_lo",  64'(LO),  64'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
